// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        SEND,
        WAIT
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]       w_start;
    logic [IDX_W:0]       w_start_mod;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    assign w_start     = {1'b0, last_grant} + 1'b1;
    assign w_start_mod = (w_start == (IDX_W+1)'(NUM_REQ)) ? '0 : w_start;

    // Rotate so the search origin lands at bit 0; the doubled vector supplies the wrap.
    assign w_rot = NUM_REQ'({req, req} >> w_start_mod);

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = w_start_mod + {1'b0, w_off};
    assign winner  = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                    : IDX_W'(w_sum);
    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx between NUM_REQ byte streams,
// with a per-grant byte cap that splits over-long packets.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done_tick,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           pkt_trunc
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    arb_state_t             r_state,      w_state_next;
    logic [IDX_W-1:0]       r_grant_id,   w_grant_next;
    logic [IDX_W-1:0]       r_last_grant, w_last_grant_next;
    logic [CNT_W-1:0]       r_cnt,        w_cnt_next;
    logic                   r_last,       w_last_next;
    logic [UART_DATA_W-1:0] r_tx_data,    w_tx_data_next;
    logic                   r_pkt_trunc,  w_pkt_trunc_next;

    logic [IDX_W-1:0]       w_winner;
    logic                   w_any_req;
    logic [UART_DATA_W-1:0] w_req_byte [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .any_req    (w_any_req)
    );

    // Ready is a pure decode of registered state, so valid never loops back into ready.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_req_byte[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
        assign req_ready[gi]  = (r_state == ACCEPT) && (r_grant_id == IDX_W'(gi));
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant_id;
        w_last_grant_next = r_last_grant;
        w_cnt_next        = r_cnt;
        w_last_next       = r_last;
        w_tx_data_next    = r_tx_data;
        w_pkt_trunc_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_next = w_winner;
                    w_cnt_next   = '0;
                    w_state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                if (req_valid[r_grant_id]) begin
                    w_tx_data_next = w_req_byte[r_grant_id];
                    w_last_next    = req_last[r_grant_id];
                    w_cnt_next     = r_cnt + CNT_W'(1);
                    w_state_next   = SEND;
                end
            end
            SEND: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (r_last || (r_cnt == CNT_W'(MAX_PKT_LEN))) begin
                        // A grant closed by the cap rather than by last is a truncation.
                        w_last_grant_next = r_grant_id;
                        w_pkt_trunc_next  = ~r_last;
                        w_state_next      = IDLE;
                    end else begin
                        w_state_next = ACCEPT;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_tx_data    <= '0;
            r_pkt_trunc  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_cnt        <= w_cnt_next;
            r_last       <= w_last_next;
            r_tx_data    <= w_tx_data_next;
            r_pkt_trunc  <= w_pkt_trunc_next;
        end
    end

    assign tx_start  = (r_state == SEND);
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != IDLE);
    assign pkt_trunc = r_pkt_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester streams, a timed uart_tx stand-in,
// and an expected-transmission scoreboard checked by each scenario task.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int MAXLEN   = 4;
    localparam int DONE_DLY = 4;
    localparam int TMO      = 300;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } src_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } tx_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done_tick;
    logic [1:0]     grant_id;
    logic           busy;
    logic           pkt_trunc;

    src_t src_q [N][$];
    tx_t  exp_q [$];
    tx_t  obs_q [$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_start = 0;
    int   trunc_cnt = 0;
    int   trunc_at = 0;
    int   hold_cnt = 0;
    bit   stray_req = 0;

    logic [N-1:0] hs;
    bit   [N-1:0] loaded = '0;
    int           wait_cnt [N];
    int           done_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .MAX_PKT_LEN (MAXLEN)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .pkt_trunc    (pkt_trunc)
    );

    always #5 clk = ~clk;

    // Requester streams and the uart_tx stand-in; inputs change 1 time unit after posedge.
    initial begin
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    loaded[i] = 1'b0;
                end
                if (src_q[i].size() == 0) begin
                    loaded[i]    = 1'b0;
                    req_valid[i] = 1'b0;
                end else begin
                    if (!loaded[i]) begin
                        wait_cnt[i] = src_q[i][0].gap;
                        loaded[i]   = 1'b1;
                    end
                    if (wait_cnt[i] > 0) begin
                        wait_cnt[i]--;
                        req_valid[i] = 1'b0;
                    end else begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = src_q[i][0].data;
                        req_last[i]        = src_q[i][0].last;
                    end
                end
            end
            tx_done_tick = 1'b0;
            if (!reset_n) done_cnt = 0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done_tick = 1'b1;
            end
            if (tx_start && reset_n) done_cnt = DONE_DLY;
            if (stray_req) begin
                tx_done_tick = 1'b1;
                stray_req    = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                obs_q.push_back('{int'(grant_id), tx_data});
                n_start++;
                $display("[TB] t=%0t tx id=%0d data=%02h", $time, grant_id, tx_data);
            end
            if (pkt_trunc) begin
                trunc_cnt++;
                trunc_at = n_start;
            end
            if ((req_ready & ~req_valid) != '0) hold_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic push(input int id, input logic [7:0] d, input logic l, input int gap);
        src_q[id].push_back('{d, l, gap});
    endtask

    task automatic expect_tx(input int id, input logic [7:0] d);
        exp_q.push_back('{id, d});
    endtask

    task automatic wait_obs(output bit ok);
        ok = 0;
        for (int c = 0; c < TMO; c++) begin
            if (obs_q.size() > 0) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            if (!busy && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && src_q[3].size() == 0) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests += 6;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        if (tx_start !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        if (tx_data !== 8'h00)     begin n_fail++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
        if (grant_id !== 2'd0)     begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (pkt_trunc !== 1'b0)    begin n_fail++; $display("FAIL reset_trunc: got %b want 0", pkt_trunc); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit ok;
        tx_t e, o;
        do_reset();
        push(0, 8'hC0, 1'b1, 0);
        push(0, 8'hC4, 1'b1, 0);
        push(1, 8'hC1, 1'b1, 0);
        push(2, 8'hC2, 1'b1, 0);
        push(3, 8'hC3, 1'b1, 0);
        expect_tx(0, 8'hC0);
        expect_tx(1, 8'hC1);
        expect_tx(2, 8'hC2);
        expect_tx(3, 8'hC3);
        expect_tx(0, 8'hC4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_order: got timeout want id %0d data %02h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL rr_order: got id %0d data %02h want id %0d data %02h", o.id, o.data, e.id, e.data);
                end
            end
        end
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rr_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_single_byte();
        bit ok;
        tx_t o;
        int c;
        int tr0;
        tr0 = trunc_cnt;
        push(2, 8'hA5, 1'b1, 0);
        c = 0;
        do begin @(negedge clk); c++; end while (!req_valid[2] && c < TMO);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_c0_busy: got %b want 0", busy); end
        @(negedge clk);
        n_tests += 2;
        if (grant_id !== 2'd2)      begin n_fail++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        @(negedge clk);
        n_tests += 2;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", tx_start); end
        if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %02h want a5", tx_data); end
        c = 0;
        do begin @(negedge clk); c++; end while (!tx_done_tick && c < TMO);
        @(negedge clk);
        n_tests += 2;
        if (busy !== 1'b0)            begin n_fail++; $display("FAIL single_idle: got busy %b want 0", busy); end
        if (trunc_cnt - tr0 !== 0)    begin n_fail++; $display("FAIL single_trunc: got %0d pulses want 0", trunc_cnt - tr0); end
        wait_obs(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_sb: got timeout want id 2 data a5");
        end else begin
            o = obs_q.pop_front();
            if (o.id !== 2 || o.data !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_sb: got id %0d data %02h want id 2 data a5", o.id, o.data);
            end
        end
    endtask

    task automatic test_stray_tick();
        bit ok;
        tx_t e, o;
        int c;
        push(2, 8'h5A, 1'b0, 0);
        push(2, 8'h5B, 1'b1, 8);
        expect_tx(2, 8'h5A);
        expect_tx(2, 8'h5B);
        c = 0;
        do begin @(negedge clk); c++; end while (!tx_done_tick && c < TMO);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0100 || req_valid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_setup: got ready %b valid %b want ready 0100 valid 0", req_ready, req_valid[2]);
        end
        stray_req = 1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL stray_ignored: got busy %b ready %b want busy 1 ready 0100", busy, req_ready);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL stray_sb: got timeout want id %0d data %02h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL stray_sb: got id %0d data %02h want id %0d data %02h", o.id, o.data, e.id, e.data);
                end
            end
        end
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stray_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_atomicity();
        bit ok;
        tx_t e, o;
        int c;
        hold_cnt = 0;
        push(1, 8'h10, 1'b0, 0);
        push(1, 8'h11, 1'b0, 0);
        push(1, 8'h12, 1'b1, 12);
        expect_tx(1, 8'h10);
        expect_tx(1, 8'h11);
        expect_tx(1, 8'h12);
        expect_tx(0, 8'h20);
        c = 0;
        do begin @(negedge clk); c++; end while (!(busy && grant_id == 2'd1) && c < TMO);
        push(0, 8'h20, 1'b1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL atom_order: got timeout want id %0d data %02h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL atom_order: got id %0d data %02h want id %0d data %02h", o.id, o.data, e.id, e.data);
                end
            end
        end
        wait_idle(ok);
        n_tests += 2;
        if (!ok)          begin n_fail++; $display("FAIL atom_idle: got busy %b want 0", busy); end
        if (hold_cnt < 5) begin n_fail++; $display("FAIL atom_gap_hold: got %0d cycles want >= 5", hold_cnt); end
    endtask

    task automatic test_cap();
        bit ok;
        tx_t e, o;
        int tr0, base;
        tr0  = trunc_cnt;
        base = n_start;
        for (int b = 0; b < 6; b++) push(3, 8'h30 + 8'(b), (b == 5), 0);
        push(0, 8'h40, 1'b1, 0);
        for (int b = 0; b < 4; b++) expect_tx(3, 8'h30 + 8'(b));
        expect_tx(0, 8'h40);
        expect_tx(3, 8'h34);
        expect_tx(3, 8'h35);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL cap_order: got timeout want id %0d data %02h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL cap_order: got id %0d data %02h want id %0d data %02h", o.id, o.data, e.id, e.data);
                end
            end
        end
        wait_idle(ok);
        n_tests += 3;
        if (!ok) begin n_fail++; $display("FAIL cap_idle: got busy %b want 0", busy); end
        if (trunc_cnt - tr0 !== 1) begin
            n_fail++;
            $display("FAIL cap_trunc_count: got %0d pulses want 1", trunc_cnt - tr0);
        end
        if (trunc_at - base !== 4) begin
            n_fail++;
            $display("FAIL cap_trunc_pos: got after byte %0d want after byte 4", trunc_at - base);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        tx_t e, o;
        push(0, 8'h50, 1'b1, 0);
        expect_tx(0, 8'h50);
        push(1, 8'h51, 1'b1, 0);
        expect_tx(1, 8'h51);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rst_pre: got timeout want id %0d data %02h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL rst_pre: got id %0d data %02h want id %0d data %02h", o.id, o.data, e.id, e.data);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || tx_data !== 8'h51) begin
            n_fail++;
            $display("FAIL rst_in_wait: got busy %b data %02h want busy 1 data 51", busy, tx_data);
        end
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        #1;
        n_tests += 5;
        if (req_ready !== 4'b0000 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_hs: got ready %b start %b want 0000 0", req_ready, tx_start);
        end
        if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_async_data: got %02h want 00", tx_data); end
        if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL rst_async_grant: got %0d want 0", grant_id); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        if (pkt_trunc !== 1'b0) begin n_fail++; $display("FAIL rst_async_trunc: got %b want 0", pkt_trunc); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(2, 8'h62, 1'b1, 0);
        push(0, 8'h60, 1'b1, 0);
        expect_tx(0, 8'h60);
        expect_tx(2, 8'h62);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rst_post: got timeout want id %0d data %02h", e.id, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL rst_post: got id %0d data %02h want id %0d data %02h", o.id, o.data, e.id, e.data);
                end
            end
        end
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rst_idle: got busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_byte();
        test_stray_tick();
        test_atomicity();
        test_cap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
